unified_mem_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory between the RV32i pipeline's instruction-fetch port (IF, read-only) and the data port (MEM stage, load/store).
- Sits between RV32iPCPU-class cores and the memory; the requester ready outputs drive the pipeline stall logic.
- Data requests have priority because they belong to the older instruction. A streak limiter prevents fetch starvation.

---
 rtl/unified_mem_arbiter_pkg.sv | 33 +++
 rtl/mem_arb_watchdog.sv | 49 ++++
 rtl/unified_mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned STREAK_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_src_e;

  // Saturating increment of the data-grant streak counter.
  function automatic logic [STREAK_W-1:0] streak_sat_inc(
    input logic [STREAK_W-1:0] cur,
    input logic [STREAK_W-1:0] max
  );
    logic [STREAK_W-1:0] nxt;
    if (cur >= max) begin
      nxt = cur;
    end else begin
      nxt = cur + STREAK_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Memory-ack watchdog: counts busy cycles without m_ack and flags expiry.
// Instantiated by unified_mem_arbiter only when UNIFIED_MEM_ARBITER_TIMEOUT_EN is defined.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic busy_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_s;

  // Next count and expiry compare; a grant always restarts the count.
  always_comb begin
    cnt_d    = cnt_q;
    expire_s = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (busy_i && !ack_i) begin
      if (cnt_q == LIMIT) begin
        expire_s = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = expire_s;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported memory between IF (read-only) and MEM (load/store) ports.
// Optional ack watchdog enabled by defining UNIFIED_MEM_ARBITER_TIMEOUT_EN.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned MAX_D_STREAK   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              arb_err
);

  localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_D_STREAK);

  arb_state_e          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic                if_ready_q, if_ready_d;
  logic                d_ready_q, d_ready_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                arb_err_q, arb_err_d;
  logic                grant_s;
  gnt_src_e            gnt_src_s;
  logic                expire_s;

`ifdef UNIFIED_MEM_ARBITER_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clr_i   (grant_s),
    .busy_i  (state_q != IDLE),
    .ack_i   (m_ack),
    .expire_o(expire_s)
  );
`else
  logic unused_timeout_s;
  assign unused_timeout_s = |TIMEOUT_CYCLES;
  assign expire_s         = 1'b0;
`endif

  // Grant selection: data wins unless it has used up its streak while a fetch waits.
  always_comb begin
    grant_s   = 1'b0;
    gnt_src_s = GNT_I;
    if (state_q == IDLE) begin
      if (d_req && (!if_req || (streak_q < MAX_S))) begin
        grant_s   = 1'b1;
        gnt_src_s = GNT_D;
      end else if (if_req) begin
        grant_s   = 1'b1;
        gnt_src_s = GNT_I;
      end else begin
        grant_s   = 1'b0;
      end
    end else begin
      grant_s = 1'b0;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    arb_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_s && (gnt_src_s == GNT_D)) begin
          state_d   = BUSY_D;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          streak_d  = if_req ? streak_sat_inc(streak_q, MAX_S) : '0;
        end else if (grant_s) begin
          state_d   = BUSY_I;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = if_addr;
          m_wdata_d = '0;
          streak_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_I: begin
        if (m_ack) begin
          state_d    = IDLE;
          m_req_d    = 1'b0;
          m_we_d     = 1'b0;
          if_ready_d = 1'b1;
          if_rdata_d = m_rdata;
        end else if (expire_s) begin
          state_d    = IDLE;
          m_req_d    = 1'b0;
          m_we_d     = 1'b0;
          if_ready_d = 1'b1;
          if_rdata_d = '0;
          arb_err_d  = 1'b1;
        end else begin
          state_d = BUSY_I;
        end
      end
      BUSY_D: begin
        if (m_ack) begin
          state_d   = IDLE;
          m_req_d   = 1'b0;
          m_we_d    = 1'b0;
          d_ready_d = 1'b1;
          d_rdata_d = m_we_q ? d_rdata_q : m_rdata;
        end else if (expire_s) begin
          state_d   = IDLE;
          m_req_d   = 1'b0;
          m_we_d    = 1'b0;
          d_ready_d = 1'b1;
          d_rdata_d = m_we_q ? d_rdata_q : '0;
          arb_err_d = 1'b1;
        end else begin
          state_d = BUSY_D;
        end
      end
      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
        m_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any request in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      arb_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      arb_err_q  <= arb_err_d;
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_ready = if_ready_q;
  assign d_ready  = d_ready_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign arb_err  = arb_err_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed, table-driven bench for unified_mem_arbiter plus multi-cycle corner sequences.
module tb_unified_mem_arbiter;

  logic        clk, rst;
  logic        if_req, if_ready, d_req, d_we, d_ready, m_req, m_we, m_ack, arb_err;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;

  int n_vec = 0;
  int n_err = 0;

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .arb_err(arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        e_m_req;
    logic        e_m_we;
    logic [31:0] e_m_addr;
    logic [31:0] e_m_wdata;
    logic        e_if_ready;
    logic        e_d_ready;
    logic [31:0] e_if_rdata;
    logic [31:0] e_d_rdata;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] mr, input logic ma,
    input logic emr, input logic emw, input logic [31:0] ema, input logic [31:0] emwd,
    input logic eir, input logic edr, input logic [31:0] eird, input logic [31:0] edrd);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da;
    v.d_wdata = dwd; v.m_rdata = mr; v.m_ack = ma;
    v.e_m_req = emr; v.e_m_we = emw; v.e_m_addr = ema; v.e_m_wdata = emwd;
    v.e_if_ready = eir; v.e_d_ready = edr; v.e_if_rdata = eird; v.e_d_rdata = edrd;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; m_rdata = 32'h0; m_ack = 1'b0;
  endtask

  string exp_order;

  initial begin
    rst = 1'b0;
    idle_inputs();

    // Table: single load, store/fetch collision, ack in IDLE, dropped request.
    vecs[0]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0,
                  1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    vecs[1]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1,
                  1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1, 32'h0, 32'hDEADBEEF);
    vecs[2]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0,
                  1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF);
    vecs[3]  = mk(1'b1, 32'h40, 1'b1, 1'b1, 32'h200, 32'h12345678, 32'h0, 1'b0,
                  1'b1, 1'b1, 32'h200, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF);
    vecs[4]  = mk(1'b1, 32'h40, 1'b1, 1'b1, 32'h200, 32'h12345678, 32'hAAAA5555, 1'b1,
                  1'b0, 1'b0, 32'h200, 32'h12345678, 1'b0, 1'b1, 32'h0, 32'hDEADBEEF);
    vecs[5]  = mk(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0,
                  1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF);
    vecs[6]  = mk(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'h13, 1'b1,
                  1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h13, 32'hDEADBEEF);
    vecs[7]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0,
                  1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h13, 32'hDEADBEEF);
    vecs[8]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b1,
                  1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h13, 32'hDEADBEEF);
    vecs[9]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 1'b0,
                  1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h13, 32'hDEADBEEF);
    vecs[10] = mk(1'b0, 32'h0,  1'b0, 1'b1, 32'h999, 32'h77, 32'h0, 1'b0,
                  1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h13, 32'hDEADBEEF);
    vecs[11] = mk(1'b0, 32'h0,  1'b0, 1'b1, 32'h999, 32'h77, 32'h55, 1'b1,
                  1'b0, 1'b0, 32'h300, 32'h0, 1'b0, 1'b1, 32'h13, 32'h55);
    vecs[12] = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0,
                  1'b0, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h13, 32'h55);

    // Reset state
    step();
    step();
    chk("reset_ctl", {59'h0, m_req, m_we, if_ready, d_ready, arb_err}, 64'h0);
    chk("reset_addr_wdata", {m_addr, m_wdata}, 64'h0);
    chk("reset_rdata", {if_rdata, d_rdata}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    step();

    for (int i = 0; i < 13; i++) begin
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_addr = vecs[i].d_addr;
      d_wdata = vecs[i].d_wdata; m_rdata = vecs[i].m_rdata; m_ack = vecs[i].m_ack;
      step();
      n_vec++;
      if (m_req !== vecs[i].e_m_req || m_we !== vecs[i].e_m_we ||
          m_addr !== vecs[i].e_m_addr || m_wdata !== vecs[i].e_m_wdata ||
          if_ready !== vecs[i].e_if_ready || d_ready !== vecs[i].e_d_ready ||
          if_rdata !== vecs[i].e_if_rdata || d_rdata !== vecs[i].e_d_rdata ||
          arb_err !== 1'b0) begin
        n_err++;
        $display("FAIL vec%0d: got req=%b we=%b addr=%h wd=%h ir=%b dr=%b ird=%h drd=%h err=%b expected req=%b we=%b addr=%h wd=%h ir=%b dr=%b ird=%h drd=%h err=0",
                 i, m_req, m_we, m_addr, m_wdata, if_ready, d_ready, if_rdata, d_rdata, arb_err,
                 vecs[i].e_m_req, vecs[i].e_m_we, vecs[i].e_m_addr, vecs[i].e_m_wdata,
                 vecs[i].e_if_ready, vecs[i].e_d_ready, vecs[i].e_if_rdata, vecs[i].e_d_rdata);
      end
    end

    // Starvation guard: both held, immediate ack; streak starts at 0.
    exp_order = "DDDDIDDD";
    if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    m_ack = 1'b0;
    step();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("grant%0d", k), {31'h0, m_req, m_addr},
          {31'h0, 1'b1, (exp_order[k] == "D") ? 32'h500 : 32'h80});
      m_ack = 1'b1; m_rdata = 32'(k);
      step();
      chk($sformatf("ready%0d", k), {62'h0, if_ready, d_ready},
          (exp_order[k] == "D") ? 64'h1 : 64'h2);
      m_ack = 1'b0;
      step();
    end
    chk("grant8_busy_d", {31'h0, m_req, m_addr}, {31'h0, 1'b1, 32'h500});

    // Asynchronous reset mid BUSY_D, then streak must restart from 0.
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst", {61'h0, m_req, d_ready, if_ready}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("post_rst_grant", {31'h0, m_req, m_addr}, {31'h0, 1'b1, 32'h500});
    m_ack = 1'b1; m_rdata = 32'h0;
    step();
    idle_inputs();
    step();

    // Wait states: 5 cycles without ack, requester changes inputs meanwhile.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h600; d_wdata = 32'hCAFEF00D;
    step();
    d_addr = 32'h1234; d_wdata = 32'h0; d_we = 1'b0;
    for (int w = 0; w < 5; w++) begin
      step();
      chk($sformatf("wait%0d_hold", w), {m_addr, m_wdata}, {32'h600, 32'hCAFEF00D});
      chk($sformatf("wait%0d_ctl", w), {59'h0, m_req, m_we, d_ready, if_ready, arb_err},
          64'h18);
    end
    m_ack = 1'b1; m_rdata = 32'h9999;
    step();
    chk("wait_done", {59'h0, m_req, m_we, d_ready, if_ready, arb_err}, 64'h4);
    chk("store_keeps_rdata", {32'h0, d_rdata}, {32'h0, 32'h0});
    idle_inputs();
    step();
    chk("wait_pulse_one", {62'h0, d_ready, m_req}, 64'h0);

`ifdef UNIFIED_MEM_ARBITER_TIMEOUT_EN
    // Load a nonzero fetch word so the timeout's zeroing is visible.
    if_req = 1'b1; if_addr = 32'h700;
    step();
    m_ack = 1'b1; m_rdata = 32'h1234;
    step();
    chk("pre_to_rdata", {32'h0, if_rdata}, {32'h0, 32'h1234});
    m_ack = 1'b0;
    step();
    for (int t = 1; t < 8; t++) begin
      step();
      chk($sformatf("to_busy%0d", t), {61'h0, m_req, if_ready, arb_err}, 64'h4);
    end
    step();
    chk("to_expire", {61'h0, m_req, if_ready, arb_err}, 64'h3);
    chk("to_rdata", {32'h0, if_rdata}, 64'h0);
    if_req = 1'b0;
    step();
    chk("to_pulse_one", {62'h0, if_ready, arb_err}, 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
